// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
//  - Register scoreboard of in-flight writes; stalls ID on RAW hazards.
//  - Injects FLUSH_CYCLES bubbles after a taken branch/jump resolved in EX.
//  - Freezes the whole pipeline while data memory holds off a request.
// Build option: define PAK_FWD_EN when the EX/MEM forwarding paths exist.
// Only loads are then tracked in the scoreboard. Otherwise every
// register-writing instruction is tracked.
module hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_rf_en,
  input  logic       id_is_load,
  input  logic       ex_redirect,
  input  logic       dmem_req,
  input  logic       dmem_gnt,
  input  logic       wb_rf_en,
  input  logic [4:0] wb_rd,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       pipe_en,
  output logic       id_issue
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t              state_q, state_d;
  state_t              saved_q, saved_d;
  state_t              eff_state;
  logic [1:0]          flush_cnt_q, flush_cnt_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                mem_wait;
  logic                hazard;
  logic                tracked;
  logic                issue_wr;

`ifdef PAK_FWD_EN
  // ALU results are forwarded; only load results arrive too late to bypass.
  assign tracked = id_is_load;
`else
  // Without forwarding every writer must reach WB before a consumer reads.
  assign tracked = 1'b1;
  logic unused_is_load;
  assign unused_is_load = id_is_load;
`endif

  // Scoreboard lookup; x0 and registers beyond NUM_REGS never report busy.
  function automatic logic reg_busy(input logic [NUM_REGS-1:0] b,
                                    input logic [4:0]          r);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (r == 5'(i)) hit = b[i];
    end
    return hit;
  endfunction

  assign mem_wait = dmem_req & ~dmem_gnt;
  assign hazard   = id_valid & ((id_rs1_used & reg_busy(busy_q, id_rs1)) |
                                (id_rs2_used & reg_busy(busy_q, id_rs2)));
  // While frozen the controller remembers where it was. On the grant cycle it
  // acts as that saved state so the pipeline advances immediately.
  assign eff_state = (state_q == MEMWAIT) ? saved_q : state_q;
  assign issue_wr  = id_issue & id_rf_en & tracked;

  // Next-state and pipeline control, priority rst > mem_wait > flush > hazard.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    saved_d     = saved_q;
    flush_cnt_d = flush_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_en     = 1'b1;
    id_issue    = 1'b0;

    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_en    = 1'b0;
    end else if (mem_wait) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
      state_d = MEMWAIT;
      if (state_q != MEMWAIT) saved_d = state_q;
    end else begin
      case (eff_state)
        FLUSH: begin
          // EX holds only bubbles here, so a redirect cannot be real.
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          flush_cnt_d = flush_cnt_q - 2'd1;
          state_d     = (flush_cnt_q <= 2'd1) ? RUN : FLUSH;
        end
        default: begin
          if (ex_redirect) begin
            // Redirect wins over a hazard; the stalled ID instruction is dropped.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cnt_d = FLUSH_INIT;
            state_d     = (FLUSH_INIT != 2'd0) ? FLUSH : RUN;
          end else if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = RUN;
          end else begin
            id_issue = id_valid;
            state_d  = RUN;
          end
        end
      endcase
    end
  end

  // Scoreboard next value: WB clears, a new writer in the same cycle re-sets.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_d[i] = (issue_wr & (id_rd == 5'(i))) |
                  (busy_q[i] & ~(wb_rf_en & ~mem_wait & (wb_rd == 5'(i))));
    end
  end

  // State, flush counter and scoreboard registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      flush_cnt_q <= 2'd0;
      // NOTE: the scoreboard is a handful of flops, not a RAM, and it must be
      // cleared: a stale busy bit after reset would stall ID forever.
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model (bubble counter + busy bit vector).
module tb_hazard_ctrl;

  localparam int FC = 2;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_rf_en, id_is_load;
  logic       ex_redirect, dmem_req, dmem_gnt, wb_rf_en;
  logic [4:0] wb_rd;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, id_issue;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_ctrl #(.NUM_REGS(32), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rf_en(id_rf_en), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_gnt(dmem_gnt),
    .wb_rf_en(wb_rf_en), .wb_rd(wb_rd),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pipe_en(pipe_en), .id_issue(id_issue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
  endtask

  function automatic logic [5:0] outs();
    return {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, id_issue};
  endfunction

  // ---------------- behavioural model ----------------
  // flush_left = bubbles still owed after the current one; busy = in-flight writers.
  int        m_flush_left = 0;
  bit [31:0] m_busy       = '0;

  function automatic bit m_tracked(input logic is_load);
`ifdef PAK_FWD_EN
    return is_load;
`else
    return (is_load | 1'b1);
`endif
  endfunction

  always @(negedge clk) begin : compare
    logic [5:0] exp;
    bit mw, hz;
    mw = dmem_req && !dmem_gnt;
    hz = id_valid && ((id_rs1_used && m_busy[id_rs1]) || (id_rs2_used && m_busy[id_rs2]));
    if (rst) begin
      exp          = 6'b001100;
      m_flush_left = 0;
      m_busy       = '0;
    end else if (mw) begin
      exp = 6'b000000;
    end else if (m_flush_left > 0) begin
      exp = 6'b111110;
      m_flush_left--;
    end else if (ex_redirect) begin
      exp          = 6'b111110;
      m_flush_left = FC - 1;
    end else if (hz) begin
      exp = 6'b000110;
    end else begin
      exp = {5'b11001, id_valid};
    end
    check("model outputs {pc,ifid_en,ifid_fl,idex_fl,pipe,issue}", 8'(outs()), 8'(exp));
    if (!rst && !mw) begin
      if (wb_rf_en) m_busy[wb_rd] = 1'b0;
      if (exp[0] && id_rf_en && id_rd != 5'd0 && m_tracked(id_is_load)) m_busy[id_rd] = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rf, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rf_en = rf; id_is_load = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic wb_clear(input logic [4:0] r);
    idle();
    wb_rf_en = 1'b1; wb_rd = r;
    look(); tick();
    wb_rf_en = 1'b0; wb_rd = 5'd0;
  endtask

  initial begin
    rst = 1'b1; idle(); ex_redirect = 1'b0; dmem_req = 1'b0; dmem_gnt = 1'b0;
    wb_rf_en = 1'b0; wb_rd = 5'd0;

    // T1: reset held 3 cycles, then RUN with all enables.
    repeat (3) begin
      look(); check("T1 reset outputs", 8'(outs()), 8'b001100); tick();
    end
    rst = 1'b0;
    look(); check("T1 run outputs", 8'(outs()), 8'b110010); tick();

    // T2: lw x5 then add x6,x5,x1 -> stall until the cycle after WB of x5.
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    look(); check("T2 lw issue", 8'(id_issue), 8'd1); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    repeat (2) begin
      look(); check("T2 stall {issue,idex_fl,pc}", 8'({id_issue, idex_flush, pc_en}), 8'b010); tick();
    end
    wb_rf_en = 1'b1; wb_rd = 5'd5;
    look(); check("T2 stall on wb cycle", 8'({id_issue, idex_flush, pc_en}), 8'b010); tick();
    wb_rf_en = 1'b0;
    look(); check("T2 issue after wb", 8'({id_issue, idex_flush, pc_en}), 8'b101); tick();
    wb_clear(5'd6);

    // T3: add x7,x2,x3 then sub x8,x7,x1.
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);
    look(); check("T3 add issue", 8'(id_issue), 8'd1); tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
`ifdef PAK_FWD_EN
    look(); check("T3 sub no stall (fwd)", 8'(id_issue), 8'd1); tick();
    wb_clear(5'd7);
`else
    look(); check("T3 sub stall", 8'(id_issue), 8'd0); tick();
    wb_rf_en = 1'b1; wb_rd = 5'd7;
    look(); check("T3 sub stall on wb", 8'(id_issue), 8'd0); tick();
    wb_rf_en = 1'b0;
    look(); check("T3 sub issue after wb", 8'(id_issue), 8'd1); tick();
`endif
    wb_clear(5'd8);

    // T4: one-cycle redirect -> exactly FC flush cycles.
    idle(); ex_redirect = 1'b1;
    look(); check("T4 flush cycle 1", 8'({ifid_flush, idex_flush}), 8'b11); tick();
    ex_redirect = 1'b0;
    look(); check("T4 flush cycle 2", 8'({ifid_flush, idex_flush}), 8'b11); tick();
    look(); check("T4 back to run", 8'({ifid_flush, idex_flush, pc_en}), 8'b001); tick();

    // T5: memory hold during a load-use stall; WB inside the freeze is ignored.
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    look(); check("T5 lw issue", 8'(id_issue), 8'd1); tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    look(); check("T5 load-use stall", 8'({pc_en, idex_flush, id_issue}), 8'b010); tick();
    dmem_req = 1'b1; dmem_gnt = 1'b0; wb_rf_en = 1'b1; wb_rd = 5'd5;
    repeat (4) begin
      look(); check("T5 freeze {pipe,pc,issue}", 8'({pipe_en, pc_en, id_issue}), 8'b000); tick();
    end
    dmem_gnt = 1'b1; wb_rf_en = 1'b0;
    look(); check("T5 stall resumes on grant", 8'({pipe_en, pc_en, idex_flush, id_issue}), 8'b1010); tick();
    dmem_req = 1'b0; dmem_gnt = 1'b0; wb_rf_en = 1'b1; wb_rd = 5'd5;
    look(); check("T5 stall on wb", 8'(id_issue), 8'd0); tick();
    wb_rf_en = 1'b0;
    look(); check("T5 issue after wb", 8'(id_issue), 8'd1); tick();
    wb_clear(5'd6);

    // T6: reset in FLUSH with x5 busy -> clean RUN, no stall on x5.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    look(); check("T6 lw issue", 8'(id_issue), 8'd1); tick();
    idle(); ex_redirect = 1'b1;
    look(); check("T6 redirect flush", 8'(ifid_flush), 8'd1); tick();
    ex_redirect = 1'b0; rst = 1'b1;
    look(); check("T6 reset in flush", 8'(outs()), 8'b001100); tick();
    rst = 1'b0;
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
    look(); check("T6 clean after reset", 8'({ifid_flush, idex_flush, id_issue}), 8'b001); tick();

    // Randomized traffic, small register window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      id_valid    = $urandom_range(0, 3) != 0;
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      id_rd       = 5'($urandom_range(0, 7));
      id_rf_en    = 1'($urandom_range(0, 1));
      id_is_load  = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 7) == 0);
      dmem_req    = ($urandom_range(0, 3) == 0);
      dmem_gnt    = 1'($urandom_range(0, 1));
      wb_rf_en    = ($urandom_range(0, 2) == 0);
      wb_rd       = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; idle(); ex_redirect = 1'b0; dmem_req = 1'b0; wb_rf_en = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
